// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Generic inter-stage pipeline register with valid/ready handshake and a
//   two-entry skid buffer. The payload is opaque; the instantiating stage packs
//   its control/data fields into DATA_W bits. A global stall (busywait) freezes
//   all transfers, and a synchronous flush squashes every held entry.
//
// Handshake: a beat moves across an interface only in a cycle where its valid
//   and ready are both high at the rising edge. Valid never waits for ready.
//   Once valid is high, the payload stays stable until that beat transfers,
//   except when a flush removes it. Here in_ready_o is additionally low during
//   stall_i or flush_i. The downstream release is also suppressed during
//   stall_i or flush_i, even though out_valid_o stays high.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   stall_i      global hold; freezes state and payloads
//   flush_i      synchronous squash of all held entries (priority over stall)
//   in_valid_i   upstream beat valid
//   in_ready_o   stage can accept a beat
//   in_data_i    upstream payload
//   out_valid_o  head entry valid
//   out_ready_i  downstream accepts the head
//   out_data_o   head payload
//   occupancy_o  held entries 0..2; this is also the raw FSM state encoding
//
// Optional build macro PIPE_STAGE_REG_STATS_EN adds two saturating counters:
//   stall_cnt_o  cycles with stall_i=1 while a head entry is valid
//   beat_cnt_o   number of releases to downstream
//   rst_ni clears both counters. flush_i does not clear them.

module pipe_stage_reg #(
    parameter int unsigned          DATA_W  = 32,
    parameter logic [DATA_W-1:0]    RST_VAL = {DATA_W{1'b0}},
    parameter int unsigned          CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
`ifdef PIPE_STAGE_REG_STATS_EN
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  beat_cnt_o,
`endif
    output logic [1:0]        occupancy_o
);

    // The encoding equals the occupancy, so occupancy_o doubles as the
    // externally visible FSM state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, skid_q;
    logic              main_valid, skid_valid;
    logic              accept, release_beat;
    logic              load_main_in, load_main_skid, load_skid_in;

    assign main_valid   = (state_q != EMPTY);
    assign skid_valid   = (state_q == FULL);

    assign in_ready_o   = ~skid_valid & ~stall_i & ~flush_i;
    assign out_valid_o  = main_valid;
    assign out_data_o   = main_q;
    assign occupancy_o  = state_q;

    assign accept       = in_valid_i & in_ready_o;
    assign release_beat = out_valid_o & out_ready_i & ~stall_i & ~flush_i;

    // Stall and flush already force accept and release low. Only the flush
    // needs its own branch, because it must also empty the stage.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && release_beat) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_d      = FULL;
                        load_skid_in = 1'b1;
                    end else if (release_beat) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // The skid entry is younger, so it becomes the new head.
                    if (release_beat) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            main_q  <= RST_VAL;
            skid_q  <= RST_VAL;
        end else begin
            state_q <= state_d;
            if (load_main_in) begin
                main_q <= in_data_i;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid_in) begin
                skid_q <= in_data_i;
            end
        end
    end

`ifdef PIPE_STAGE_REG_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, beat_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            if (stall_i && out_valid_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (release_beat && (beat_cnt_q != {CNT_W{1'b1}})) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign beat_cnt_o  = beat_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg. A nonzero RST_VAL is used so that
// reset-loaded payloads can be told apart from zero data.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam logic [DATA_W-1:0] RST_VAL = 32'hDEAD_BEEF;

  // clock/reset block
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic              stall_i, flush_i, in_valid_i, in_ready_o;
  logic [DATA_W-1:0] in_data_i, out_data_o;
  logic              out_valid_o, out_ready_i;
  logic [1:0]        occupancy_o;
`ifdef PIPE_STAGE_REG_STATS_EN
  logic [CNT_W-1:0]  stall_cnt_o, beat_cnt_o;
`endif

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .RST_VAL(RST_VAL),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
`ifdef PIPE_STAGE_REG_STATS_EN
    .stall_cnt_o(stall_cnt_o),
    .beat_cnt_o (beat_cnt_o),
`endif
    .occupancy_o(occupancy_o)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic rdy);
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = rdy;
    #1;
  endtask

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic v, input logic [1:0] occ,
                            input logic [DATA_W-1:0] d);
    check({tag, "_valid"}, DATA_W'(out_valid_o), DATA_W'(v));
    check({tag, "_occ"},   DATA_W'(occupancy_o), DATA_W'(occ));
    check({tag, "_data"},  out_data_o, d);
  endtask

  initial begin
    rst_ni = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    in_data_i = '0;
    out_ready_i = 1'b0;
    tick();
    tick();
    check_head("rst", 1'b0, 2'd0, RST_VAL);
    rst_ni = 1'b1;
    #1;
    check("rst_in_ready", DATA_W'(in_ready_o), 32'd1);

    // streaming at full rate
    drive(1'b1, 32'h11, 1'b1);
    tick();
    check_head("s0", 1'b1, 2'd1, 32'h11);
    check("s0_rdy", DATA_W'(in_ready_o), 32'd1);
    drive(1'b1, 32'h22, 1'b1);
    tick();
    check_head("s1", 1'b1, 2'd1, 32'h22);
    check("s1_rdy", DATA_W'(in_ready_o), 32'd1);
    drive(1'b1, 32'h33, 1'b1);
    tick();
    check_head("s2", 1'b1, 2'd1, 32'h33);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    check_head("s_drain", 1'b0, 2'd0, 32'h33);

    // backpressure into the skid register
    drive(1'b1, 32'hA0, 1'b0);
    tick();
    check_head("bp0", 1'b1, 2'd1, 32'hA0);
    drive(1'b1, 32'hA1, 1'b0);
    tick();
    check_head("bp_full", 1'b1, 2'd2, 32'hA0);
    check("bp_rdy", DATA_W'(in_ready_o), 32'd0);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    check_head("bp_rel0", 1'b1, 2'd1, 32'hA1);
    tick();
    check_head("bp_rel1", 1'b0, 2'd0, 32'hA1);

    // stall holds everything
    drive(1'b1, 32'h55, 1'b0);
    tick();
    check_head("st_load", 1'b1, 2'd1, 32'h55);
    stall_i = 1'b1;
    drive(1'b1, 32'h66, 1'b1);
    check("st_rdy", DATA_W'(in_ready_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_head("st_hold", 1'b1, 2'd1, 32'h55);
    end
    stall_i = 1'b0;
    #1;
    check("st_rdy_back", DATA_W'(in_ready_o), 32'd1);
    tick();
    check_head("st_release", 1'b1, 2'd1, 32'h66);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    check_head("st_drain", 1'b0, 2'd0, 32'h66);

    // flush squashes a full stage and refuses the input beat
    drive(1'b1, 32'hB0, 1'b0);
    tick();
    drive(1'b1, 32'hB1, 1'b0);
    tick();
    check_head("fl_full", 1'b1, 2'd2, 32'hB0);
    flush_i = 1'b1;
    drive(1'b1, 32'hB2, 1'b1);
    check("fl_rdy", DATA_W'(in_ready_o), 32'd0);
    tick();
    check("fl_valid", DATA_W'(out_valid_o), 32'd0);
    check("fl_occ", DATA_W'(occupancy_o), 32'd0);
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    tick();
    check("fl_after_occ", DATA_W'(occupancy_o), 32'd0);

    // asynchronous reset mid-cycle while full
    drive(1'b1, 32'hC0, 1'b0);
    tick();
    drive(1'b1, 32'hC1, 1'b0);
    tick();
    check_head("ar_full", 1'b1, 2'd2, 32'hC0);
    drive(1'b0, 32'h0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check_head("ar_rst", 1'b0, 2'd0, RST_VAL);
    tick();
    rst_ni = 1'b1;
    #1;
    check("ar_rdy", DATA_W'(in_ready_o), 32'd1);
    drive(1'b1, 32'hC2, 1'b1);
    tick();
    check_head("ar_after", 1'b1, 2'd1, 32'hC2);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    check_head("ar_drain", 1'b0, 2'd0, 32'hC2);

`ifdef PIPE_STAGE_REG_STATS_EN
    // counters: clear on reset, then 4 stall cycles and 5 releases
    rst_ni = 1'b0;
    #1;
    check("cnt_rst_stall", DATA_W'(stall_cnt_o), 32'd0);
    check("cnt_rst_beat", DATA_W'(beat_cnt_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    drive(1'b1, 32'hD0, 1'b0);
    tick();
    stall_i = 1'b1;
    drive(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    stall_i = 1'b0;
    #1;
    check("cnt_stall", DATA_W'(stall_cnt_o), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DATA_W'(32'hD0 + i), 1'b1);
      tick();
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    check("cnt_beat", DATA_W'(beat_cnt_o), 32'd5);
    check("cnt_stall_kept", DATA_W'(stall_cnt_o), 32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the RISC-V core. It is the successor to the fixed-field IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Carries an opaque DATA_W-bit payload. The instantiating stage packs its control and data fields into that payload.
- Adds a valid/ready handshake, a 2-entry skid buffer (full throughput with a registered-style backpressure path), a global stall (busywait) and a synchronous flush for branch/exception squash.
- Sits between any two pipeline stages.

Parameters:
- DATA_W, 32, payload width in bits (>=1).
- RST_VAL, {DATA_W{1'b0}}, value loaded into both payload registers on reset.
- CNT_W, 16, width of statistics counters (used only with the optional feature).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- stall_i  in  1  global hold (memory busywait); freezes all transfers.
- flush_i  in  1  synchronous squash of all held entries.
- in_valid_i  in  1  upstream beat valid.
- in_ready_o  out  1  stage can accept a beat.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream accepts the head.
- out_data_o  out  DATA_W  head payload.
- occupancy_o  out  2  number of held entries (0..2).

Behaviour:
- Storage: main register (head, drives out_data_o) plus skid register. Each has its own valid bit.
- State encoding: EMPTY (0 entries), ONE (main valid), FULL (main and skid valid). occupancy_o = 0/1/2 respectively.
- Reset (rst_ni=0, asynchronous assert, synchronous-safe deassert):
  - State goes to EMPTY, out_valid_o=0, occupancy_o=0.
  - Main and skid payloads are set to RST_VAL, so out_data_o=RST_VAL.
  - Reset overrides everything, including mid-operation.
- Handshake definitions:
  - in_ready_o = (state!=FULL) & ~stall_i & ~flush_i.
  - out_valid_o = (state!=EMPTY). out_valid_o is not gated by stall_i.
  - accept = in_valid_i & in_ready_o.
  - release = out_valid_o & out_ready_i & ~stall_i & ~flush_i.
  - A beat is never dropped or duplicated.
- Transitions, evaluated at the rising edge; flush_i has the highest priority after reset:
  - flush_i=1: next state EMPTY from any state. Payload registers are unchanged. The input beat in that cycle is not accepted, because in_ready_o=0.
  - stall_i=1 (no flush): state and payloads hold unchanged.
  - EMPTY: accept -> ONE, main<=in_data_i.
  - ONE: accept&release -> ONE, main<=in_data_i. accept only -> FULL, skid<=in_data_i. release only -> EMPTY.
  - FULL: release -> ONE, main<=skid. No accept is possible, since in_ready_o=0.
- Latency: a beat accepted at edge N is presented on out_data_o with out_valid_o=1 after edge N.
- Throughput: 1 beat/cycle while out_ready_i=1 and stall_i=0.
- Ordering: strict FIFO. The skid entry is always younger than the main entry.
- out_data_o is stable while out_valid_o=1 and the head has not been released.
- Payload of an invalid entry is don't-care for consumers, but must not be X after reset.

Optional Feature:
- Macro: PIPE_STAGE_REG_STATS_EN.
- Defined: adds outputs stall_cnt_o[CNT_W] and beat_cnt_o[CNT_W].
  - stall_cnt_o increments each cycle with stall_i=1 & out_valid_o=1.
  - beat_cnt_o increments on each release.
  - Both counters saturate at all-ones, are cleared by rst_ni=0 and are not cleared by flush_i.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. Reset: drive rst_ni=0 asynchronously mid-cycle with state FULL -> immediately out_valid_o=0, occupancy_o=0, out_data_o=RST_VAL; after release, in_ready_o=1.
2. Streaming: out_ready_i=1, send 0x11,0x22,0x33 on consecutive cycles -> out_data_o shows 0x11,0x22,0x33 on the next 3 cycles, occupancy_o stays 1, in_ready_o stays 1.
3. Backpressure: out_ready_i=0, send 0xA0,0xA1 -> occupancy_o=2, in_ready_o=0, out_data_o=0xA0. Then out_ready_i=1 for 2 cycles -> 0xA0 then 0xA1 released, state EMPTY.
4. Stall: ONE holding 0x55, stall_i=1 for 3 cycles with in_valid_i=1, in_data_i=0x66, out_ready_i=1 -> in_ready_o=0, out_data_o=0x55 and out_valid_o=1 held. stall_i=0 -> 0x55 released, 0x66 accepted.
5. Flush: FULL (0xB0,0xB1), flush_i=1 with in_valid_i=1, in_data_i=0xB2 -> next cycle occupancy_o=0, out_valid_o=0, 0xB2 not accepted, no beat released.
6. Stats (PIPE_STAGE_REG_STATS_EN): 4 stall cycles with valid head, then 5 releases -> stall_cnt_o=4, beat_cnt_o=5. Force counters to all-ones and repeat -> values stay at all-ones.
